cntn_b: RTL

CNTN_B -- requirements
Module: cntn_b

---
 rtl/cntn_b.sv | 93 +++++++++
 1 files changed

// File: rtl/cntn_b.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : cntn_b                                                              |
// | Desc   : Step-select up/down counter, modulo MAX+1 with wrap pulse; define   |
// |          CNTN_SATURATE_EN to clamp at 0/MAX instead of wrapping.             |
// | Rev    : 1.0 - initial release                                               |
// +-----------------------------------------------------------------------------+
module cntn_b #(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH-1,
   parameter int STEP0 = 1,
   parameter int STEP1 = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             x,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             at_max
);

   // Arithmetic runs one bit wider so count+step never overflows, even at MAX=2**WIDTH-1
   localparam logic [WIDTH:0]   c_max   = (WIDTH+1)'(MAX);
   localparam logic [WIDTH-1:0] c_max_w = WIDTH'(MAX);
   localparam logic [WIDTH:0]   c_step0 = (WIDTH+1)'(STEP0);
   localparam logic [WIDTH:0]   c_step1 = (WIDTH+1)'(STEP1);
`ifndef CNTN_SATURATE_EN
   localparam logic [WIDTH:0]   c_mod   = (WIDTH+1)'(MAX + 1);
`endif

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH:0]   w_cnt_ext;
   logic [WIDTH:0]   w_step;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

   always_comb begin
      w_cnt_ext = {1'b0, r_count};
      w_step    = x ? c_step1 : c_step0;
      w_sum     = w_cnt_ext + w_step;
      w_next    = r_count;
      w_wrap    = 1'b0;
      if (load) begin
         w_next = (load_val > c_max_w) ? c_max_w : load_val;
      end else if (en) begin
         if (!dir) begin
            if (w_sum <= c_max) begin
               w_next = WIDTH'(w_sum);
            end else begin
               w_wrap = 1'b1;
`ifdef CNTN_SATURATE_EN
               w_next = c_max_w;
`else
               w_next = WIDTH'(w_sum - c_mod);
`endif
            end
         end else begin
            if (w_cnt_ext >= w_step) begin
               w_next = WIDTH'(w_cnt_ext - w_step);
            end else begin
               w_wrap = 1'b1;
`ifdef CNTN_SATURATE_EN
               w_next = '0;
`else
               w_next = WIDTH'(w_cnt_ext + c_mod - w_step);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next;
         r_wrap  <= w_wrap;
      end
   end

   assign count  = r_count;
   assign wrap   = r_wrap;
   assign at_max = (r_count == c_max_w);

endmodule
`default_nettype wire
